// File: rtl/inst_sram_responder_if.sv
// rtl/inst_sram_responder_if.sv - instruction SRAM request/response bus between fetch front end and responder
interface inst_sram_responder_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        rdata_valid;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata, rdata_valid
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata, rdata_valid
  );
endinterface

// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - instruction SRAM responder: one-cycle read, byte-lane writes, preload, error capture, counters
module inst_sram_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h1c000000,
  parameter logic [31:0] ERR_DATA  = 32'h03400000,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  inst_sram_responder_if.slave  bus,
  input  logic                  init_we,
  input  logic [IDX_W-1:0]      init_idx,
  input  logic [31:0]           init_data,
  output logic                  err_flag,
  output logic [31:0]           err_addr,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [CNT_W-1:0]      wr_cnt
);

  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

  logic [31:0]      mem [DEPTH];
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             legal;
  logic             is_write;
  logic [31:0]      cur_word;
  logic [31:0]      merged_word;

  // Unsigned difference makes addresses below BASE_ADDR wrap high and fail the range test.
  always_comb begin
    offset      = bus.inst_sram_addr - BASE_ADDR;
    idx         = offset[IDX_W+1:2];
    legal       = (bus.inst_sram_addr[1:0] == 2'b00) && (offset < SPAN);
    is_write    = |bus.inst_sram_we;
    cur_word    = mem[idx];
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (bus.inst_sram_we[i]) begin
        merged_word[8*i +: 8] = bus.inst_sram_wdata[8*i +: 8];
      end
    end
  end

  // Array has no reset so contents survive resetn; a live request beats the preload port.
  always_ff @(posedge clk) begin
    if (bus.inst_sram_en) begin
      if (legal && is_write) begin
        mem[idx] <= merged_word;
      end
    end else if (init_we) begin
      mem[init_idx] <= init_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.inst_sram_rdata <= 32'h0;
      bus.rdata_valid     <= 1'b0;
      err_flag            <= 1'b0;
      err_addr            <= 32'h0;
      rd_cnt              <= '0;
      wr_cnt              <= '0;
    end else begin
      bus.rdata_valid <= bus.inst_sram_en;
      if (bus.inst_sram_en) begin
        if (legal) begin
          bus.inst_sram_rdata <= merged_word;
          if (is_write) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end else begin
          bus.inst_sram_rdata <= ERR_DATA;
          if (!err_flag) begin
            err_flag <= 1'b1;
            err_addr <= bus.inst_sram_addr;
          end
        end
      end
    end
  end

endmodule
